// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: PC, synchronous imem requests, instruction FIFO, redirect/flush
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instruction,
   output logic [31:0] instr_pc,
   output logic        misalign_err
);

   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } state_t;

   state_t          state, state_nx;
   logic [31:0]     pc;
   logic [31:0]     tag;
   logic            inflight;
   logic [31:0]     buf_data [FIFO_DEPTH];
   logic [31:0]     buf_pc   [FIFO_DEPTH];
   logic [AW-1:0]   wptr, rptr;
   logic [AW:0]     count;
   logic [AW+1:0]   occ;
   logic            pop, push, flush;

   assign instr_valid  = (count != '0);
   assign pop          = instr_valid && instr_ready;
   assign instruction  = buf_data[rptr];
   assign instr_pc     = buf_pc[rptr];
   assign imem_addr    = pc;
   assign misalign_err = (state == HALT);

   // Occupancy counts the outstanding request so a response can never overflow the FIFO.
   assign occ = (AW+2)'(count) + (AW+2)'(inflight) - (AW+2)'(pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      imem_req = 1'b0;
      flush    = 1'b0;
      case (state)
         RUN: begin
            if (redirect_valid) begin
               flush = 1'b1;
               if (redirect_pc[1:0] != 2'b00) begin
                  state_nx = HALT;
               end
            end else begin
               imem_req = !rst && (occ < (AW+2)'(FIFO_DEPTH));
            end
         end
         HALT: begin
            flush = 1'b1;
         end
         default: begin
            state_nx = RUN;
         end
      endcase
      push = inflight && !flush;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc       <= RESET_PC;
         tag      <= RESET_PC;
         inflight <= 1'b0;
         count    <= '0;
         wptr     <= '0;
         rptr     <= '0;
      end else begin
         inflight <= imem_req;
         if (imem_req) begin
            pc  <= pc + 32'd4;
            tag <= pc;
         end else if (redirect_valid && state == RUN) begin
            pc <= redirect_pc;
         end
         if (flush) begin
            count <= '0;
            wptr  <= '0;
            rptr  <= '0;
         end else begin
            if (push) begin
               wptr <= wptr + AW'(1);
            end
            if (pop) begin
               rptr <= rptr + AW'(1);
            end
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         buf_data[wptr] <= imem_rdata;
         buf_pc[wptr]   <= tag;
      end
   end

endmodule
